led_cube_layer_scanner: RTL and testbench

//  Downstream display stage of the cube controller. It takes per-layer column patterns

---
 rtl/led_cube_layer_scanner_if.sv | 36 +++
 rtl/led_cube_layer_scanner.sv | 148 ++++++++++++++
 tb/tb_led_cube_layer_scanner.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/led_cube_layer_scanner_if.sv
// Command/display bundle for the LED cube layer scanner.
// LED_CUBE_BRIGHTNESS_EN adds the brightness input.
interface led_cube_layer_scanner_if #(
  parameter int N_LAYERS = 4,
  parameter int N_COLS   = 16
);
  localparam int LW = $clog2(N_LAYERS);

  logic              wr_en;
  logic [LW-1:0]     wr_layer;
  logic [N_COLS-1:0] wr_data;
  logic              commit;
  logic [N_COLS-1:0] col_out;
  logic [N_LAYERS-1:0] layer_out;
  logic              swap_pending;
  logic              frame_done;
`ifdef LED_CUBE_BRIGHTNESS_EN
  logic [3:0]        brightness;
`endif

  modport master (
    output wr_en, wr_layer, wr_data, commit,
    input  col_out, layer_out, swap_pending, frame_done
`ifdef LED_CUBE_BRIGHTNESS_EN
    , output brightness
`endif
  );

  modport slave (
    input  wr_en, wr_layer, wr_data, commit,
    output col_out, layer_out, swap_pending, frame_done
`ifdef LED_CUBE_BRIGHTNESS_EN
    , input brightness
`endif
  );
endinterface

// File: rtl/led_cube_layer_scanner.sv
// Double-buffered LED cube layer scanner: blank/drive time multiplexing with tear-free swap.
// LED_CUBE_BRIGHTNESS_EN adds per-dwell column duty control via bus.brightness.
module led_cube_layer_scanner #(
  parameter int N_LAYERS     = 4,
  parameter int N_COLS       = 16,
  parameter int DWELL_CYCLES = 12500,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                     clk,
  input  logic                     reset,
  led_cube_layer_scanner_if.slave  bus
);
  localparam int LW    = $clog2(N_LAYERS);
  localparam int MAXC  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW    = $clog2(MAXC + 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_COLS-1:0]   col_q, col_d;
  logic [N_LAYERS-1:0] layer_q, layer_d;
  logic                front_sel_q;
  logic                pend_q;
  logic                boundary;
  logic                wr_ok;
  logic [N_COLS-1:0]   front_row;

  logic [N_COLS-1:0] buf0 [N_LAYERS];
  logic [N_COLS-1:0] buf1 [N_LAYERS];

`ifdef LED_CUBE_BRIGHTNESS_EN
  logic [N_COLS-1:0] pat_q, pat_d;
  logic [CW-1:0]     limit_q, limit_d, limit_now;
  assign limit_now = CW'(((32'(bus.brightness) + 32'd1) * 32'(DWELL_CYCLES)) >> 4);
`endif

  // Non-power-of-two layer counts leave unused wr_layer codes that must be dropped.
  if ((1 << LW) == N_LAYERS) begin : g_pow2
    assign wr_ok = 1'b1;
  end else begin : g_npow2
    assign wr_ok = 32'(bus.wr_layer) < N_LAYERS;
  end

  assign front_row = front_sel_q ? buf1[idx_q] : buf0[idx_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CW'(1);
    col_d    = '0;
    layer_d  = '0;
    boundary = 1'b0;
`ifdef LED_CUBE_BRIGHTNESS_EN
    pat_d    = pat_q;
    limit_d  = limit_q;
`endif
    case (state_q)
      S_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
          layer_d = N_LAYERS'(1) << idx_q;
`ifdef LED_CUBE_BRIGHTNESS_EN
          pat_d   = front_row;
          limit_d = limit_now;
          col_d   = (limit_now != '0) ? front_row : '0;
`else
          col_d   = front_row;
`endif
        end
      end
      S_DRIVE: begin
        layer_d = layer_q;
`ifdef LED_CUBE_BRIGHTNESS_EN
        col_d   = (cnt_d < limit_q) ? pat_q : '0;
`else
        col_d   = col_q;
`endif
        if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
          state_d  = S_BLANK;
          cnt_d    = '0;
          layer_d  = '0;
          col_d    = '0;
          boundary = (idx_q == LW'(N_LAYERS - 1));
          idx_d    = boundary ? '0 : idx_q + LW'(1);
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
      layer_q <= '0;
`ifdef LED_CUBE_BRIGHTNESS_EN
      pat_q   <= '0;
      limit_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      layer_q <= layer_d;
`ifdef LED_CUBE_BRIGHTNESS_EN
      pat_q   <= pat_d;
      limit_q <= limit_d;
`endif
    end
  end

  // A commit on the boundary cycle swaps immediately without ever raising pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel_q <= 1'b0;
      pend_q      <= 1'b0;
    end else if (boundary) begin
      if (pend_q || bus.commit) front_sel_q <= ~front_sel_q;
      pend_q <= 1'b0;
    end else if (bus.commit) begin
      pend_q <= 1'b1;
    end
  end

  // Writes use the pre-edge front_sel, so a write on the swap edge joins the new front.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_LAYERS; i++) begin
        buf0[i] <= '0;
        buf1[i] <= '0;
      end
    end else if (bus.wr_en && wr_ok) begin
      if (front_sel_q) buf0[bus.wr_layer] <= bus.wr_data;
      else             buf1[bus.wr_layer] <= bus.wr_data;
    end
  end

  assign bus.col_out      = col_q;
  assign bus.layer_out    = layer_q;
  assign bus.swap_pending = pend_q;
  assign bus.frame_done   = boundary;
endmodule

// File: tb/tb_led_cube_layer_scanner.sv
// Directed self-checking bench for led_cube_layer_scanner (4 layers, 16 cols, dwell 8, blank 2).
module tb_led_cube_layer_scanner;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   on_cycles = 8;

  always #5 clk = ~clk;

  led_cube_layer_scanner_if #(.N_LAYERS(4), .N_COLS(16)) bus ();

  led_cube_layer_scanner #(
    .N_LAYERS(4), .N_COLS(16), .DWELL_CYCLES(8), .BLANK_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc = (cyc + 1) % 40;
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 40 && cyc != p; i++) step();
  endtask

  task automatic write(input logic [1:0] layer, input logic [15:0] data);
    bus.wr_en = 1'b1; bus.wr_layer = layer; bus.wr_data = data;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
  endtask

  // One full frame from frame position 0: slot = 2 blank + 8 drive cycles.
  task automatic check_frame(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3, input logic ep);
    logic [15:0] exp_col [4];
    logic [15:0] ec;
    logic [3:0]  el;
    int slot, pos;
    exp_col = '{e0, e1, e2, e3};
    for (int c = 0; c < 40; c++) begin
      slot = c / 10;
      pos  = c % 10;
      el = (pos < 2) ? 4'd0 : (4'd1 << slot);
      ec = (pos >= 2 && (pos - 2) < on_cycles) ? exp_col[slot] : 16'd0;
      check($sformatf("%s.layer@%0d", tag, c), 32'(bus.layer_out), 32'(el));
      check($sformatf("%s.col@%0d", tag, c), 32'(bus.col_out), 32'(ec));
      check($sformatf("%s.fdone@%0d", tag, c), 32'(bus.frame_done), 32'(c == 39));
      check($sformatf("%s.pend@%0d", tag, c), 32'(bus.swap_pending), 32'(ep));
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_layer = '0; bus.wr_data = '0; bus.commit = 1'b0;
`ifdef LED_CUBE_BRIGHTNESS_EN
    bus.brightness = 4'd15;
`endif
    repeat (3) step();
    check("rst.col", 32'(bus.col_out), 32'h0);
    check("rst.layer", 32'(bus.layer_out), 32'h0);
    check("rst.pend", 32'(bus.swap_pending), 32'h0);
    check("rst.fdone", 32'(bus.frame_done), 32'h0);
    reset = 1'b0;
    cyc = 0;

    // 1: idle scan of a cleared frame store
    check_frame("idle", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    // 2: load a pattern then commit mid-frame
    write(2'd0, 16'h0001); write(2'd1, 16'h0002); write(2'd2, 16'h0004); write(2'd3, 16'h0008);
    pulse_commit();
    check("commit.pend_rise", 32'(bus.swap_pending), 32'h1);
    run_to(39);
    check("commit.pend_at_bnd", 32'(bus.swap_pending), 32'h1);
    check("commit.fdone_at_bnd", 32'(bus.frame_done), 32'h1);
    step();
    check_frame("swap1", 16'h0001, 16'h0002, 16'h0004, 16'h0008, 1'b0);

    // 3: back-buffer writes without commit leave the display alone
    write(2'd0, 16'hFFFF); write(2'd1, 16'hFFFF); write(2'd2, 16'hFFFF); write(2'd3, 16'hFFFF);
    run_to(0);
    check_frame("noswapA", 16'h0001, 16'h0002, 16'h0004, 16'h0008, 1'b0);
    check_frame("noswapB", 16'h0001, 16'h0002, 16'h0004, 16'h0008, 1'b0);

    // 4: commit on the boundary cycle swaps at once; double commit swaps once
    run_to(39);
    check("bndcommit.fdone", 32'(bus.frame_done), 32'h1);
    pulse_commit();
    check_frame("bndswap", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    run_to(5);
    bus.commit = 1'b1;
    step();
    step();
    bus.commit = 1'b0;
    check("dbl.pend", 32'(bus.swap_pending), 32'h1);
    run_to(0);
    check_frame("dblA", 16'h0001, 16'h0002, 16'h0004, 16'h0008, 1'b0);
    check_frame("dblB", 16'h0001, 16'h0002, 16'h0004, 16'h0008, 1'b0);

    // 5: write on the swap edge, and write+commit together
    run_to(10);
    pulse_commit();
    run_to(39);
    write(2'd2, 16'hA5A5);
    check_frame("edgewr", 16'hFFFF, 16'hFFFF, 16'hA5A5, 16'hFFFF, 1'b0);
    run_to(20);
    bus.wr_en = 1'b1; bus.wr_layer = 2'd0; bus.wr_data = 16'h1234; bus.commit = 1'b1;
    step();
    bus.wr_en = 1'b0; bus.commit = 1'b0;
    run_to(0);
    check_frame("wrcommit", 16'h1234, 16'h0002, 16'h0004, 16'h0008, 1'b0);

    // 6: reset during layer 2 drive with a pending swap
    run_to(3);
    pulse_commit();
    run_to(25);
    check("midrst.layer_pre", 32'(bus.layer_out), 32'h4);
    check("midrst.pend_pre", 32'(bus.swap_pending), 32'h1);
    reset = 1'b1;
    step();
    check("midrst.col", 32'(bus.col_out), 32'h0);
    check("midrst.layer", 32'(bus.layer_out), 32'h0);
    check("midrst.pend", 32'(bus.swap_pending), 32'h0);
    reset = 1'b0;
    cyc = 0;
    check_frame("postrst", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

`ifdef LED_CUBE_BRIGHTNESS_EN
    write(2'd0, 16'hFFFF); write(2'd1, 16'hFFFF); write(2'd2, 16'hFFFF); write(2'd3, 16'hFFFF);
    pulse_commit();
    bus.brightness = 4'd3;
    on_cycles = 2;
    run_to(0);
    check_frame("bright3", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    bus.brightness = 4'd15;
    on_cycles = 8;
    check_frame("bright15", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
